uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver, 8N1, LSB-first. It is the receive-side counterpart of the team's UART transmitter and shares its bit timing via CLKS_PER_BIT.
- Synchronises the asynchronous serial input.
- Validates the start bit at mid-bit and samples each data bit at mid-bit.
- Checks the stop bit and presents each byte with a one-cycle valid strobe.
- Sits between the board RX pin and the RFID command parser.

Parameters:
CLKS_PER_BIT, 87, system clocks per serial bit. Legal range 4..65535; the bit counter is 16 bits.

Ports:
i_Clock  input  1  system clock; all logic on rising edge
i_Reset  input  1  synchronous, active-high reset
i_Rx_Serial  input  1  asynchronous serial line, idle high
o_Rx_DV  output  1  one-cycle strobe: o_Rx_Byte holds a newly received valid byte
o_Rx_Byte  output  8  last correctly framed byte; held until the next valid byte
o_Rx_Frame_Err  output  1  one-cycle strobe: stop bit sampled low
o_Rx_Active  output  1  high while a frame is being received

Behaviour:
- Reset values, synchronous when i_Reset=1:
  - o_Rx_DV=0, o_Rx_Frame_Err=0, o_Rx_Active=0, o_Rx_Byte=8'h00.
  - Both synchroniser flops=1; state=IDLE; counter=0; bit index=0.
- Reset applied mid-frame aborts the frame with no strobe. Reception restarts cleanly on the next falling edge after release.
- Synchroniser: two flops in series on i_Rx_Serial. The second flop output is r_Rx; all state logic uses only r_Rx.
- Constant H = (CLKS_PER_BIT-1)/2, integer division.
- o_Rx_DV and o_Rx_Frame_Err default to 0 every cycle. They are never high together.
- States:
  - IDLE: counter=0, index=0, Active=0. If r_Rx=0, go to START and set Active=1.
  - START: increment counter until counter==H.
    - At counter==H with r_Rx=0: counter=0, go to DATA.
    - At counter==H with r_Rx=1: glitch rejected; go to IDLE, Active=0, no strobe.
  - DATA: at counter==CLKS_PER_BIT-1:
    - Store r_Rx into shift register bit [index] and reset counter=0.
    - If index<7, increment index; at index 7, clear index and go to STOP.
    - Otherwise increment counter.
  - STOP: at counter==CLKS_PER_BIT-1:
    - If r_Rx=1: o_Rx_Byte<=shift register and o_Rx_DV<=1.
    - If r_Rx=0: o_Rx_Frame_Err<=1 and o_Rx_Byte is unchanged.
    - Either way: Active<=0, go to CLEANUP.
  - CLEANUP: stay until r_Rx=1, then go to IDLE. This handles break: a low line after a framing error never starts a new frame until it has gone high.
  - Any illegal encoding: go to IDLE.
- Latency: edge 0 is the first clock edge at which the synchroniser samples the low start bit. The DV or Frame_Err strobe is high in the cycle after edge 3+H+9*CLKS_PER_BIT.
  - CLKS_PER_BIT=87 gives edge 829.
  - CLKS_PER_BIT=8 gives edge 78.
- Sample point: data bit k is sampled 3+H clocks after its nominal start. This tolerates at least ±2% baud mismatch at CLKS_PER_BIT≥16.
- Back-to-back frames: the start bit immediately after a one-bit stop is accepted, because CLEANUP exits when the line is high and IDLE detects the next falling edge.
- No buffering. A consumer must take o_Rx_Byte within one frame time. Overrun is not detected.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, CLEANUP), 3-bit;
  - DATA_BITS=8;
  - common to uart_tx and uart_rx.
- One sub-module, sync_2ff: parameterised-width two-flop synchroniser with reset value 1. It is reusable for other asynchronous inputs.
- Shift register, counter and FSM stay in uart_rx.

Test Plan:
1. CLKS_PER_BIT=8, send 0xA5 with correct framing from idle → o_Rx_DV high for exactly 1 cycle after edge 78; o_Rx_Byte=0xA5; o_Rx_Frame_Err never high.
2. Idle line with a 2-cycle low glitch → no DV, no Frame_Err; o_Rx_Active high for ≤H+3 cycles, then 0. A valid 0x5A sent afterwards is received.
3. Send 0x3C with stop bit driven 0, then hold the line low for 20 bit times → one Frame_Err pulse, no DV, o_Rx_Byte keeps the previous value, no further strobes while low. After the line returns high, 0x81 is received correctly.
4. Back-to-back 0x00, 0xFF, 0x55 with exactly one stop bit each → three DV pulses spaced 10*CLKS_PER_BIT cycles apart, with bytes in order.
5. Assert i_Reset for 1 cycle during data bit 4 of 0xC3 → all outputs return to reset values next cycle and no strobe for that frame. A following 0x96 is received correctly.
6. Loopback uart_tx→uart_rx at CLKS_PER_BIT=87 with all 256 byte values, then an external driver at bit periods of 85 and 89 clocks → every byte matches, zero framing errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: the frame FSM
// encoding, data width and the bit-timing helpers that derive from CLKS_PER_BIT.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(DATA_BITS);
  localparam int CNT_W     = 16;

  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [DATA_BITS-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_e;

  // Clocks from the detected start edge to the middle of the start bit.
  function automatic cnt_t half_bit(input int clks_per_bit);
    return cnt_t'((clks_per_bit - 1) / 2);
  endfunction

  function automatic cnt_t last_clk(input int clks_per_bit);
    return cnt_t'(clks_per_bit - 1);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle between the RX pin, the receiver and the command parser.
interface uart_rx_if
  import uart_pkg::*;
  ;
  logic  i_Rx_Serial;
  logic  o_Rx_DV;
  data_t o_Rx_Byte;
  logic  o_Rx_Frame_Err;
  logic  o_Rx_Active;

  // The receiver drives the byte bus; the pin side and consumer own the rest.
  modport master (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Frame_Err,
    output o_Rx_Active
  );

  modport slave (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Frame_Err,
    input  o_Rx_Active
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; resets to RESET_VAL so an
// idle-high line does not look like an edge when reset is released.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic [WIDTH-1:0] i_Async,
  output logic [WIDTH-1:0] o_Sync
);

  logic [WIDTH-1:0] r_Meta;

  // NOTE: non-blocking assignments make the two stages a true shift; blocking
  // would collapse them into a single flop.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Meta <= RESET_VAL;
      o_Sync <= RESET_VAL;
    end else begin
      r_Meta <= i_Async;
      o_Sync <= r_Meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver: mid-bit start validation and sampling, stop-bit
// check, one-cycle valid / frame-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic      i_Clock,
  input  logic      i_Reset,
  uart_rx_if.master rx
);

  localparam cnt_t HALF = half_bit(CLKS_PER_BIT);
  localparam cnt_t LAST = last_clk(CLKS_PER_BIT);
  localparam idx_t LAST_IDX = idx_t'(DATA_BITS - 1);

  uart_state_e r_State;
  cnt_t        r_Count;
  idx_t        r_Index;
  data_t       r_Shift;
  data_t       r_Rx_Byte;
  logic        r_Rx_DV;
  logic        r_Rx_Frame_Err;
  logic        r_Rx_Active;
  logic        r_Rx;

  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (rx.i_Rx_Serial),
    .o_Sync  (r_Rx)
  );

  wire w_Bit_End = (r_Count == LAST);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State        <= IDLE;
      r_Count        <= '0;
      r_Index        <= '0;
      r_Rx_Byte      <= '0;
      r_Rx_DV        <= 1'b0;
      r_Rx_Frame_Err <= 1'b0;
      r_Rx_Active    <= 1'b0;
    end else begin
      r_Rx_DV        <= 1'b0;
      r_Rx_Frame_Err <= 1'b0;

      case (r_State)
        IDLE: begin
          r_Count     <= '0;
          r_Index     <= '0;
          r_Rx_Active <= 1'b0;
          if (!r_Rx) begin
            r_State     <= START;
            r_Rx_Active <= 1'b1;
          end
        end

        // A line that is high again at mid start bit was only a glitch.
        START: begin
          if (r_Count == HALF) begin
            r_Count <= '0;
            if (!r_Rx) begin
              r_State <= DATA;
            end else begin
              r_State     <= IDLE;
              r_Rx_Active <= 1'b0;
            end
          end else begin
            r_Count <= r_Count + cnt_t'(1);
          end
        end

        DATA: begin
          if (w_Bit_End) begin
            r_Count <= '0;
            if (r_Index == LAST_IDX) begin
              r_Index <= '0;
              r_State <= STOP;
            end else begin
              r_Index <= r_Index + idx_t'(1);
            end
          end else begin
            r_Count <= r_Count + cnt_t'(1);
          end
        end

        STOP: begin
          if (w_Bit_End) begin
            r_Count     <= '0;
            r_Rx_Active <= 1'b0;
            r_State     <= CLEANUP;
            if (r_Rx) begin
              r_Rx_Byte <= r_Shift;
              r_Rx_DV   <= 1'b1;
            end else begin
              r_Rx_Frame_Err <= 1'b1;
            end
          end else begin
            r_Count <= r_Count + cnt_t'(1);
          end
        end

        // Wait out a break: a line held low must return high before re-arming.
        CLEANUP: begin
          if (r_Rx) begin
            r_State <= IDLE;
          end
        end

        default: begin
          r_State     <= IDLE;
          r_Count     <= '0;
          r_Index     <= '0;
          r_Rx_Active <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the shift register is pure datapath and is only published after a
  // full frame, so it carries no reset and avoids a reset-gated enable.
  always_ff @(posedge i_Clock) begin
    if (r_State == DATA && w_Bit_End) begin
      r_Shift[r_Index] <= r_Rx;
    end
  end

  assign rx.o_Rx_DV        = r_Rx_DV;
  assign rx.o_Rx_Byte      = r_Rx_Byte;
  assign rx.o_Rx_Frame_Err = r_Rx_Frame_Err;
  assign rx.o_Rx_Active    = r_Rx_Active;

endmodule
